// File: rtl/mips_bus_arbiter.sv
// Round-robin Avalon-MM master front-end: N_CH word requesters share one bus.
// Optional macro BUS_TIMEOUT_EN adds a waitrequest timeout (MAX_WAIT cycles).
module mips_bus_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int N_CH     = 2,
    parameter int MAX_WAIT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CH-1:0]            req_valid,
    input  logic [N_CH-1:0]            req_write,
    input  logic [N_CH*ADDR_W-1:0]     req_addr,
    input  logic [N_CH*DATA_W-1:0]     req_wdata,
    input  logic [N_CH*(DATA_W/8)-1:0] req_be,
    output logic [N_CH-1:0]            resp_valid,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic                       resp_err,
    output logic                       busy,
    output logic [ADDR_W-1:0]          address,
    output logic                       read,
    output logic                       write,
    input  logic                       waitrequest,
    output logic [DATA_W-1:0]          writedata,
    output logic [DATA_W/8-1:0]        byteenable,
    input  logic [DATA_W-1:0]          readdata
);

    localparam int          BE_W = DATA_W / 8;
    localparam int          LSB  = $clog2(BE_W);
    localparam int          CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned NCH  = N_CH;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((64'd1 << LSB) - 64'd1);

    if (N_CH < 1 || N_CH > 8 || (DATA_W % 8) != 0 || MAX_WAIT < 1) begin : g_param_check
        $error("mips_bus_arbiter: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state;
    logic [CH_W-1:0]   last_grant;
    logic              is_write;

    logic [CH_W-1:0]   sel;
    logic              found;
    int unsigned       idx;
    logic [N_CH-1:0]   rot;
    logic [N_CH-1:0]   dir_rot;
    logic              g_write;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [BE_W-1:0]   g_be;

    // Search starts one past the previous winner, so a continuously
    // requesting channel can never win twice in a row while others wait.
    always_comb begin
        sel     = last_grant;
        found   = 1'b0;
        idx     = 0;
        rot     = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = (32'(last_grant) + k) % NCH;
            rot = req_valid >> idx;
            if (!found && rot[0]) begin
                sel   = CH_W'(idx);
                found = 1'b1;
            end
        end
        dir_rot = req_write >> sel;
        g_write = dir_rot[0];
        g_addr  = req_addr[sel*ADDR_W +: ADDR_W];
        g_wdata = req_wdata[sel*DATA_W +: DATA_W];
        g_be    = req_be[sel*BE_W +: BE_W];
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(MAX_WAIT + 1);
    logic [TW-1:0] wait_cnt;
    logic          err_q;
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= CH_W'(N_CH - 1);
            is_write   <= 1'b0;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            resp_rdata <= '0;
            resp_valid <= '0;
            busy       <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= '0;
                    if (found) begin
                        last_grant <= sel;
                        address    <= g_addr & ADDR_MASK;
                        writedata  <= g_wdata;
                        byteenable <= g_be;
                        is_write   <= g_write;
                        busy       <= 1'b1;
`ifdef BUS_TIMEOUT_EN
                        wait_cnt   <= '0;
                        err_q      <= 1'b0;
`endif
                        // No enabled bytes: complete without touching the bus.
                        if (g_be == '0) begin
                            resp_valid <= N_CH'(1) << sel;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            read  <= ~g_write;
                            write <= g_write;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!waitrequest) begin
                        read       <= 1'b0;
                        write      <= 1'b0;
                        if (!is_write)
                            resp_rdata <= readdata;
                        resp_valid <= N_CH'(1) << last_grant;
                        state      <= RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    // Compare against MAX_WAIT-1 so the strobe is high for exactly MAX_WAIT cycles.
                    else if (wait_cnt == TW'(MAX_WAIT - 1)) begin
                        read       <= 1'b0;
                        write      <= 1'b0;
                        if (!is_write)
                            resp_rdata <= '1;
                        err_q      <= 1'b1;
                        resp_valid <= N_CH'(1) << last_grant;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    resp_valid <= '0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench for mips_bus_arbiter (N_CH=2, 32-bit bus).
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    int checks = 0;
    int errors = 0;

    mips_bus_arbiter #(
        .DATA_W(32), .ADDR_W(32), .N_CH(2), .MAX_WAIT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .address(address), .read(read), .write(write),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        waitrequest = 1'b0;
        readdata    = '0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_strobes", 64'({read, write}), 64'd0);
        chk("rst_addr", 64'(address), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", 64'(resp_rdata), 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        reset = 1'b0;
        tick();

        // ch0 read, zero wait, unaligned address
        req_addr[31:0] = 32'h0000_0106;
        req_be[3:0]    = 4'hF;
        req_valid      = 2'b01;
        readdata       = 32'hDEAD_BEEF;
        tick();
        chk("t1_read", 64'({read, write}), 64'b10);
        chk("t1_addr", 64'(address), 64'h104);
        chk("t1_be", 64'(byteenable), 64'hF);
        chk("t1_no_resp_yet", 64'(resp_valid), 64'd0);
        tick();
        chk("t1_strobe_drop", 64'({read, write}), 64'd0);
        chk("t1_resp_valid", 64'(resp_valid), 64'b01);
        chk("t1_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);
        req_valid = '0;
        tick();
        chk("t1_resp_pulse", 64'(resp_valid), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);

        // ch1 write with waitrequest high for 4 cycles
        req_addr[63:32]  = 32'h0000_0020;
        req_wdata[63:32] = 32'h1234_5678;
        req_be[7:4]      = 4'h3;
        req_write        = 2'b10;
        req_valid        = 2'b10;
        waitrequest      = 1'b1;
        readdata         = 32'hBAD0_BAD0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) waitrequest = 1'b0;
            chk("t2_write_stable", 64'({read, write}), 64'b01);
            chk("t2_addr_stable", 64'(address), 64'h20);
            chk("t2_wdata_stable", 64'(writedata), 64'h1234_5678);
            chk("t2_be_stable", 64'(byteenable), 64'h3);
            chk("t2_no_resp", 64'(resp_valid), 64'd0);
            tick();
        end
        chk("t2_strobe_drop", 64'({read, write}), 64'd0);
        chk("t2_resp_valid", 64'(resp_valid), 64'b10);
        chk("t2_rdata_kept", 64'(resp_rdata), 64'hDEAD_BEEF);
        req_valid = '0;
        req_write = '0;
        tick();
        chk("t2_resp_pulse", 64'(resp_valid), 64'd0);

        // both channels requesting continuously: grants alternate 0,1,0,1
        req_addr[31:0]  = 32'h0000_0100;
        req_addr[63:32] = 32'h0000_0200;
        req_be          = 8'hFF;
        req_valid       = 2'b11;
        for (int t = 0; t < 4; t++) begin
            readdata = 32'hA000_0000 + 32'(t);
            tick();
            chk("t3_read", 64'(read), 64'd1);
            chk("t3_grant_addr", 64'(address), (t % 2 == 0) ? 64'h100 : 64'h200);
            tick();
            chk("t3_resp_valid", 64'(resp_valid), (t % 2 == 0) ? 64'b01 : 64'b10);
            chk("t3_rdata", 64'(resp_rdata), 64'hA000_0000 + 64'(t));
            tick();
            chk("t3_idle", 64'(busy), 64'd0);
        end
        req_valid = '0;

        // zero byte enables: no bus cycle, immediate response with rdata 0
        req_be[3:0] = 4'h0;
        req_valid   = 2'b01;
        readdata    = 32'h5555_5555;
        tick();
        chk("t4_no_strobe", 64'({read, write}), 64'd0);
        chk("t4_resp_valid", 64'(resp_valid), 64'b01);
        chk("t4_rdata_zero", 64'(resp_rdata), 64'd0);
        req_valid = '0;
        tick();
        chk("t4_no_strobe2", 64'({read, write}), 64'd0);
        chk("t4_resp_pulse", 64'(resp_valid), 64'd0);
        req_be[3:0] = 4'hF;

        // reset asserted mid-ISSUE
        req_valid   = 2'b10;
        waitrequest = 1'b1;
        tick();
        chk("t5_read", 64'(read), 64'd1);
        chk("t5_addr", 64'(address), 64'h200);
        tick();
        tick();
        #3 reset = 1'b1;
        #1;
        chk("t5_async_drop", 64'({read, write}), 64'd0);
        chk("t5_no_resp", 64'(resp_valid), 64'd0);
        chk("t5_busy_clr", 64'(busy), 64'd0);
        tick();
        reset       = 1'b0;
        req_valid   = 2'b11;
        waitrequest = 1'b0;
        readdata    = 32'h0BAD_F00D;
        tick();
        chk("t5_ch0_first", 64'(address), 64'h100);
        tick();
        chk("t5_resp_valid", 64'(resp_valid), 64'b01);
        req_valid = '0;
        tick();

        // waitrequest stuck high on a read
        req_valid   = 2'b01;
        waitrequest = 1'b1;
        readdata    = 32'h1111_2222;
`ifdef BUS_TIMEOUT_EN
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("t6_read_held", 64'(read), 64'd1);
            tick();
        end
        chk("t6_timeout_drop", 64'(read), 64'd0);
        chk("t6_resp_valid", 64'(resp_valid), 64'b01);
        chk("t6_resp_err", 64'(resp_err), 64'd1);
        chk("t6_rdata_ones", 64'(resp_rdata), 64'hFFFF_FFFF);
        req_valid = '0;
        tick();
`else
        tick();
        repeat (110) tick();
        chk("t6_read_held", 64'(read), 64'd1);
        chk("t6_no_resp", 64'(resp_valid), 64'd0);
        chk("t6_err_zero", 64'(resp_err), 64'd0);
        chk("t6_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_valid = '0;
`endif
        waitrequest = 1'b0;
        tick();
        chk("end_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
